// File: rtl/tdc_pkg.sv
// Shared constants, fine-code width helper and timestamp type for the TDC channel.
package tdc_pkg;

    localparam int DEF_NTAPS    = 32;
    localparam int DEF_COARSE_W = 16;

    // Width needed to hold a fine code in the range 0..ntaps.
    function automatic int tdc_fine_w(input int ntaps);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < (ntaps + 1)) w = i + 1;
        end
        return w;
    endfunction

    localparam int DEF_FINE_W = tdc_fine_w(DEF_NTAPS);

    typedef struct packed {
        logic [DEF_COARSE_W-1:0] coarse;
        logic [DEF_FINE_W-1:0]   fine;
    } tdc_ts_t;

endpackage

// File: rtl/tdc_channel_if.sv
// Timestamp channel bus: tap inputs, consumer handshake and status outputs.
interface tdc_channel_if
    import tdc_pkg::*;
#(
    parameter int NTAPS    = DEF_NTAPS,
    parameter int COARSE_W = DEF_COARSE_W
);
    localparam int FINE_W = tdc_fine_w(NTAPS);

    logic [NTAPS-1:0]    taps_in;
    logic                out_ready;
    logic                ovf_clr;
    logic                out_valid;
    logic [COARSE_W-1:0] out_coarse;
    logic [FINE_W-1:0]   out_fine;
    logic                coarse_wrap;
    logic                ovf;
    logic [7:0]          drop_cnt;

    modport master (
        input  taps_in, out_ready, ovf_clr,
        output out_valid, out_coarse, out_fine, coarse_wrap, ovf, drop_cnt
    );

    modport slave (
        output taps_in, out_ready, ovf_clr,
        input  out_valid, out_coarse, out_fine, coarse_wrap, ovf, drop_cnt
    );

endinterface

// File: rtl/tdc_thermo2bin.sv
// Thermometer-to-binary fine encoder. TDC_BUBBLE_CORR_EN selects a majority-filtered
// popcount; otherwise the code is the run of ones starting at tap 0.
module tdc_thermo2bin
    import tdc_pkg::*;
#(
    parameter  int NTAPS  = DEF_NTAPS,
    localparam int FINE_W = tdc_fine_w(NTAPS)
) (
    input  logic [NTAPS-1:0]  thermo,
    output logic [FINE_W-1:0] fine
);

`ifdef TDC_BUBBLE_CORR_EN
    // Edge taps are padded with their own value so the filter never invents a bit.
    logic [NTAPS+1:0] pad;
    logic [NTAPS-1:0] filt;
    int               ones;

    assign pad = {thermo[NTAPS-1], thermo, thermo[0]};

    always_comb begin
        filt = '0;
        ones = 0;
        for (int i = 0; i < NTAPS; i++) begin
            filt[i] = (pad[i] & pad[i+1]) | (pad[i+1] & pad[i+2]) | (pad[i] & pad[i+2]);
            ones    = ones + int'(filt[i]);
        end
        fine = FINE_W'(ones);
    end
`else
    logic run;
    int   ones;

    always_comb begin
        run  = 1'b1;
        ones = 0;
        for (int i = 0; i < NTAPS; i++) begin
            run  = run & thermo[i];
            ones = ones + int'(run);
        end
        fine = FINE_W'(ones);
    end
`endif

endmodule

// File: rtl/tdc_channel.sv
// Single TDC channel: tap sampling pipeline, coarse counter, hit detect and
// one-deep timestamp output with drop accounting. Optional macro: TDC_BUBBLE_CORR_EN.
module tdc_channel
    import tdc_pkg::*;
#(
    parameter int NTAPS    = DEF_NTAPS,
    parameter int COARSE_W = DEF_COARSE_W
) (
    input logic           clk,
    input logic           rst_n,
    tdc_channel_if.master bus
);

    localparam int                  FINE_W  = tdc_fine_w(NTAPS);
    localparam logic [COARSE_W-1:0] CNT_MAX = '1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [COARSE_W-1:0] cnt;
    logic                wrap_q;

    logic [NTAPS-1:0]    taps_p0, taps_p1, taps_p2;
    logic [COARSE_W-1:0] coarse_p0, coarse_p1, coarse_p2;
    logic                vld_p0, vld_p1, vld_p2;
    logic                hit_p1, hit_p2;
    logic [FINE_W-1:0]   fine_p1, fine_p2;

    logic                ts_vld;
    logic [COARSE_W-1:0] ts_coarse;
    logic [FINE_W-1:0]   ts_fine;
    logic                ovf_q;
    logic [7:0]          drop_q;
    logic                load, drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt    <= cnt + COARSE_W'(1);
            wrap_q <= (cnt == CNT_MAX);
        end
    end

    tdc_thermo2bin #(.NTAPS(NTAPS)) u_thermo2bin (
        .thermo (taps_p1),
        .fine   (fine_p1)
    );

    // vld_p2 keeps the zeroed reset contents of s2 from posing as a low level.
    assign hit_p1 = vld_p2 & taps_p1[0] & ~taps_p2[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_p0   <= '0;
            taps_p1   <= '0;
            taps_p2   <= '0;
            coarse_p0 <= '0;
            coarse_p1 <= '0;
            coarse_p2 <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            hit_p2    <= 1'b0;
            fine_p2   <= '0;
        end else begin
            // s0: raw tap capture with the coarse count of this edge
            taps_p0   <= bus.taps_in;
            coarse_p0 <= cnt;
            vld_p0    <= 1'b1;
            // s1: metastability re-register
            taps_p1   <= taps_p0;
            coarse_p1 <= coarse_p0;
            vld_p1    <= vld_p0;
            // s2: previous s1 word plus the encoded hit from s1
            taps_p2   <= taps_p1;
            vld_p2    <= vld_p1;
            hit_p2    <= hit_p1;
            fine_p2   <= fine_p1;
            coarse_p2 <= coarse_p1;
        end
    end

    assign load = hit_p2 & (~ts_vld | bus.out_ready);
    assign drop = hit_p2 & ts_vld & ~bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_vld    <= 1'b0;
            ts_coarse <= '0;
            ts_fine   <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            // output stage: one-deep holding register
            if (load) begin
                ts_vld    <= 1'b1;
                ts_coarse <= coarse_p2;
                ts_fine   <= fine_p2;
            end else if (bus.out_ready) begin
                ts_vld    <= 1'b0;
            end
            // A drop coinciding with a clear restarts the count at one.
            if (drop) begin
                ovf_q  <= 1'b1;
                drop_q <= bus.ovf_clr ? 8'd1 : sat_inc(drop_q);
            end else if (bus.ovf_clr) begin
                ovf_q  <= 1'b0;
                drop_q <= '0;
            end
        end
    end

    assign bus.out_valid   = ts_vld;
    assign bus.out_coarse  = ts_coarse;
    assign bus.out_fine    = ts_fine;
    assign bus.coarse_wrap = wrap_q;
    assign bus.ovf         = ovf_q;
    assign bus.drop_cnt    = drop_q;

endmodule

// File: tb/tb_tdc_channel.sv
// Directed bench for tdc_channel: table of tap patterns plus hand-written
// sequences for back-pressure, drop counting, coarse wrap and mid-pipeline reset.
module tb_tdc_channel;
    import tdc_pkg::*;

    logic clk;
    logic rst_n;
    logic rst4_n;

    tdc_channel_if #(.NTAPS(32), .COARSE_W(16)) bus  ();
    tdc_channel_if #(.NTAPS(32), .COARSE_W(4))  bus4 ();

    tdc_channel #(.NTAPS(32), .COARSE_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    tdc_channel #(.NTAPS(32), .COARSE_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] taps;
        int          fine;
        int          hold;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap, cap_a, cap_e;

        vecs[0] = '{32'h0000_00FF, 8, 4};
        vecs[1] = '{32'hFFFF_FFFF, 32, 25};
        vecs[2] = '{32'h0000_0001, 1, 4};
        vecs[3] = '{32'h0000_FFFF, 16, 4};
        vecs[4] = '{32'h7FFF_FFFF, 31, 4};
`ifdef TDC_BUBBLE_CORR_EN
        vecs[5] = '{32'h0000_00F7, 8, 4};
        vecs[6] = '{32'h0000_0005, 2, 4};
        vecs[7] = '{32'h0F0F_0F0F, 16, 4};
`else
        vecs[5] = '{32'h0000_00F7, 3, 4};
        vecs[6] = '{32'h0000_0005, 1, 4};
        vecs[7] = '{32'h0F0F_0F0F, 4, 4};
`endif

        rst_n  = 1'b0;
        rst4_n = 1'b0;
        bus.taps_in  = '0;
        bus.out_ready = 1'b1;
        bus.ovf_clr  = 1'b0;
        bus4.taps_in = '0;
        bus4.out_ready = 1'b1;
        bus4.ovf_clr = 1'b0;
        repeat (3) tick();

        check("rst_out_valid",   64'(bus.out_valid),   0);
        check("rst_out_coarse",  64'(bus.out_coarse),  0);
        check("rst_out_fine",    64'(bus.out_fine),    0);
        check("rst_coarse_wrap", 64'(bus.coarse_wrap), 0);
        check("rst_ovf",         64'(bus.ovf),         0);
        check("rst_drop_cnt",    64'(bus.drop_cnt),    0);

        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_out_valid",   64'(bus.out_valid),   0);
            check("idle_ovf",         64'(bus.ovf),         0);
            check("idle_coarse_wrap", 64'(bus.coarse_wrap), 0);
        end

        // Table: one rising edge per vector, held high, then released.
        for (int v = 0; v < 8; v++) begin
            bus.taps_in = '0;
            repeat (3) tick();
            cap = cyc;
            bus.taps_in = vecs[v].taps;
            tick();
            tick();
            tick();
            check($sformatf("vec%0d_latency_early", v), 64'(bus.out_valid), 0);
            tick();
            check($sformatf("vec%0d_valid", v),  64'(bus.out_valid),  1);
            check($sformatf("vec%0d_fine", v),   64'(bus.out_fine),   64'(vecs[v].fine));
            check($sformatf("vec%0d_coarse", v), 64'(bus.out_coarse), 64'(cap));
            tick();
            check($sformatf("vec%0d_pulse_end", v), 64'(bus.out_valid), 0);
            for (int h = 0; h < vecs[v].hold; h++) begin
                tick();
                check($sformatf("vec%0d_steady_high", v), 64'(bus.out_valid), 0);
            end
            bus.taps_in = '0;
            for (int h = 0; h < 5; h++) begin
                tick();
                check($sformatf("vec%0d_falling", v), 64'(bus.out_valid), 0);
            end
        end

        // Back-pressure: first hit held, next two dropped.
        bus.out_ready = 1'b0;
        repeat (3) tick();
        cap_a = cyc;
        for (int k = 0; k < 3; k++) begin
            bus.taps_in = 32'h1;
            tick();
            tick();
            bus.taps_in = '0;
            repeat (3) tick();
        end
        repeat (2) tick();
        check("bp_valid_held", 64'(bus.out_valid),  1);
        check("bp_coarse",     64'(bus.out_coarse), 64'(cap_a));
        check("bp_fine",       64'(bus.out_fine),   1);
        check("bp_ovf",        64'(bus.ovf),        1);
        check("bp_drop_cnt",   64'(bus.drop_cnt),   2);

        // Drop and clear on the same edge.
        bus.taps_in = 32'h1;
        tick();
        bus.taps_in = '0;
        tick();
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("clr_drop_ovf",      64'(bus.ovf),        1);
        check("clr_drop_cnt",      64'(bus.drop_cnt),   1);
        check("clr_drop_coarse",   64'(bus.out_coarse), 64'(cap_a));
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("clr_ovf",           64'(bus.ovf),        0);
        check("clr_drop_cnt_zero", 64'(bus.drop_cnt),   0);
        check("clr_valid_kept",    64'(bus.out_valid),  1);

        // Hit arriving with out_ready=1 replaces the held timestamp, no drop.
        repeat (2) tick();
        cap_e = cyc;
        bus.taps_in = 32'h1;
        tick();
        bus.taps_in = '0;
        tick();
        tick();
        bus.out_ready = 1'b1;
        tick();
        check("replace_valid",  64'(bus.out_valid),  1);
        check("replace_coarse", 64'(bus.out_coarse), 64'(cap_e));
        check("replace_nodrop", 64'(bus.drop_cnt),   0);
        tick();
        check("replace_drain",  64'(bus.out_valid),  0);

        // Drop counter saturation.
        bus.out_ready = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 262; k++) begin
            bus.taps_in = 32'h1;
            tick();
            bus.taps_in = '0;
            tick();
        end
        repeat (4) tick();
        check("sat_drop_cnt", 64'(bus.drop_cnt), 255);
        check("sat_ovf",      64'(bus.ovf),      1);
        bus.ovf_clr   = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("sat_clr_cnt",   64'(bus.drop_cnt),  0);
        check("sat_clr_valid", 64'(bus.out_valid), 0);

        // Narrow coarse counter: hit at count 15 and wrap pulse.
        check("w4_rst_valid",  64'(bus4.out_valid),   0);
        check("w4_rst_wrap",   64'(bus4.coarse_wrap), 0);
        rst4_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("w4_no_wrap", 64'(bus4.coarse_wrap), 0);
        end
        bus4.taps_in = 32'h1;
        tick();
        check("w4_wrap_pulse", 64'(bus4.coarse_wrap), 1);
        tick();
        check("w4_wrap_end",   64'(bus4.coarse_wrap), 0);
        tick();
        check("w4_latency_early", 64'(bus4.out_valid), 0);
        tick();
        check("w4_valid",  64'(bus4.out_valid),  1);
        check("w4_coarse", 64'(bus4.out_coarse), 15);
        check("w4_fine",   64'(bus4.out_fine),   1);
        for (int i = 0; i < 13; i++) begin
            tick();
            check("w4_second_wrap", 64'(bus4.coarse_wrap), (i == 12) ? 64'd1 : 64'd0);
        end

        // Reset mid-pipeline discards the hit; taps still high after release.
        bus4.taps_in = '0;
        repeat (3) tick();
        bus4.taps_in = 32'h1;
        tick();
        tick();
        rst4_n = 1'b0;
        #1;
        check("w4_async_valid",  64'(bus4.out_valid),  0);
        check("w4_async_coarse", 64'(bus4.out_coarse), 0);
        check("w4_async_fine",   64'(bus4.out_fine),   0);
        repeat (2) tick();
        rst4_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("w4_post_rst_valid", 64'(bus4.out_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
